// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch unit: PC owner, memory read initiator, fetch FIFO (optional FETCH_ALIGN_CHECK_EN)
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_enable,
   output logic        mem_read,
   output logic [63:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        fault
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [63:0]    pc;
   logic [CW-1:0]  count;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [31:0]    fifo_word [FIFO_DEPTH];
   logic [63:0]    fifo_pc   [FIFO_DEPTH];

   logic           redirect_take;
   logic           misaligned;
   logic [63:0]    aligned_pc;
   logic           fetch;
   logic           pop;

   // Once faulted the unit is frozen, so redirects no longer have any effect.
   assign redirect_take = redirect_valid && (state != S_FAULT);
   assign aligned_pc    = redirect_pc & {{62{1'b1}}, 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = (redirect_pc[1:0] != 2'b00);
   assign fault      = (state == S_FAULT);
`else
   assign misaligned = 1'b0;
   assign fault      = 1'b0;
`endif

   assign mem_read    = 1'b1;
   assign mem_data_in = 32'h0;
   assign mem_address = pc;

   // A push happens exactly when memory is accessed; a redirect already masks mem_enable.
   assign fetch = mem_enable;
   assign pop   = instr_valid && instr_ready && !redirect_take;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: leave idle on the first edge, fault only on a misaligned redirect.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = (redirect_take && misaligned) ? S_FAULT : S_RUN;
         S_RUN:   if (redirect_take && misaligned) state_nxt = S_FAULT;
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: fetch while running with room (no pop bypass), present the FIFO head.
   always_comb begin
      mem_enable  = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0;
      instr_pc    = 64'h0;
      if (state == S_RUN) begin
         mem_enable = (count < CW'(FIFO_DEPTH)) && !redirect_valid;
      end
      if ((state != S_FAULT) && (count != '0)) begin
         instr_valid = 1'b1;
         instr       = fifo_word[rd_ptr];
         instr_pc    = fifo_pc[rd_ptr];
      end
   end

   // PC, occupancy and pointers; a redirect wins over any coincident push or pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc     <= RESET_PC;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (redirect_take) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         if (!misaligned) begin
            pc <= aligned_pc;
         end
      end else begin
         if (fetch) begin
            pc     <= pc + 64'd4;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(fetch) - CW'(pop);
      end
   end

   // FIFO storage: capture the word returned by the combinational memory with its PC.
   always_ff @(posedge clk) begin
      if (fetch) begin
         fifo_word[wr_ptr] <= mem_data_out;
         fifo_pc[wr_ptr]   <= pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_enable;
   logic        mem_read;
   logic [63:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        fault;

   int total = 0;
   int bad   = 0;

   instruction_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_enable     (mem_enable),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_data_out   (mem_data_out),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] wfn(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
   endfunction

   assign mem_data_out = wfn(mem_address);

   // reference model: fetch address, queue of buffered PCs, started/fault flags
   logic [63:0] m_pc;
   logic [63:0] m_q[$];
   bit          m_started;
   bit          m_fault;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'h0;
      m_q.delete();
      m_started = 0;
      m_fault = 0;
   endtask

   task automatic drive(input logic rv, input logic [63:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      instr_ready    = rdy;
      #1;
   endtask

   task automatic tick();
      bit do_fetch;
      bit do_pop;
      @(posedge clk);
      do_fetch = m_started && !m_fault && (m_q.size() < DEPTH) && !redirect_valid;
      do_pop   = (m_q.size() != 0) && instr_ready && !m_fault;
      if (redirect_valid && !m_fault) begin
         m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) m_fault = 1;
         else m_pc = redirect_pc;
`else
         m_pc = {redirect_pc[63:2], 2'b00};
`endif
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (do_fetch) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 64'd4;
         end
      end
      m_started = 1;
      @(negedge clk);
   endtask

   task automatic check_model();
      logic          e_en;
      logic          e_v;
      logic [63:0]   e_pc;
      e_en = m_started && !m_fault && (m_q.size() < DEPTH) && !redirect_valid;
      e_v  = (m_q.size() != 0);
      e_pc = e_v ? m_q[0] : 64'h0;
      chk("rnd_en", {63'h0, mem_enable}, {63'h0, e_en});
      chk("rnd_addr", mem_address, m_pc);
      chk("rnd_valid", {63'h0, instr_valid}, {63'h0, e_v});
      chk("rnd_pc", instr_pc, e_pc);
      chk("rnd_instr", {32'h0, instr}, {32'h0, e_v ? wfn(e_pc) : 32'h0});
      chk("rnd_fault", {63'h0, fault}, {63'h0, m_fault});
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_en"}, {63'h0, mem_enable}, 64'h0);
      chk({nm, "_valid"}, {63'h0, instr_valid}, 64'h0);
      chk({nm, "_instr"}, {32'h0, instr}, 64'h0);
      chk({nm, "_pc"}, instr_pc, 64'h0);
      chk({nm, "_addr"}, mem_address, 64'h0);
      chk({nm, "_fault"}, {63'h0, fault}, 64'h0);
      chk({nm, "_read"}, {63'h0, mem_read}, 64'h1);
      chk({nm, "_wdata"}, {32'h0, mem_data_in}, 64'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 64'h0;
      instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_zero_outputs("reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        rv;
      logic [63:0] rpc;
      logic        rdy;
      logic        e_en;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [63:0] e_pc;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // cycles after reset release: stream with ready=1, then stall to full, then resume
      tbl[0]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
      tbl[1]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
      tbl[2]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'd4,  1'b1, 64'd0};
      tbl[3]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'd8,  1'b1, 64'd4};
      tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'd12, 1'b1, 64'd8};
      tbl[5]  = '{1'b0, 64'h0, 1'b0, 1'b1, 64'd16, 1'b1, 64'd12};
      tbl[6]  = '{1'b0, 64'h0, 1'b0, 1'b1, 64'd20, 1'b1, 64'd12};
      tbl[7]  = '{1'b0, 64'h0, 1'b0, 1'b1, 64'd24, 1'b1, 64'd12};
      tbl[8]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'd28, 1'b1, 64'd12};
      tbl[9]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'd28, 1'b1, 64'd12};
      tbl[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'd28, 1'b1, 64'd16};
      tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'd32, 1'b1, 64'd20};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
         chk($sformatf("tbl%0d_en", i), {63'h0, mem_enable}, {63'h0, tbl[i].e_en});
         chk($sformatf("tbl%0d_addr", i), mem_address, tbl[i].e_addr);
         chk($sformatf("tbl%0d_valid", i), {63'h0, instr_valid}, {63'h0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_valid ? tbl[i].e_pc : 64'h0);
         chk($sformatf("tbl%0d_instr", i), {32'h0, instr},
             {32'h0, tbl[i].e_valid ? wfn(tbl[i].e_pc) : 32'h0});
         tick();
      end

      // redirect to 8 while three entries are buffered
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 64'h0, 1'b0);
         tick();
      end
      drive(1'b1, 64'h8, 1'b0);
      chk("redir_full3_pc", instr_pc, 64'h0);
      chk("redir_en_masked", {63'h0, mem_enable}, 64'h0);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("redir_bubble_valid", {63'h0, instr_valid}, 64'h0);
      chk("redir_fetch_addr", mem_address, 64'h8);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 64'h0, 1'b1);
         chk($sformatf("redir_stream%0d_pc", i), instr_pc, 64'h8 + 64'(4 * i));
         chk($sformatf("redir_stream%0d_valid", i), {63'h0, instr_valid}, 64'h1);
         tick();
      end

      // PC wraparound, then redirect coinciding with a pop
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
      tick();
      drive(1'b0, 64'h0, 1'b0);
      chk("wrap_addr0", mem_address, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      drive(1'b0, 64'h0, 1'b0);
      chk("wrap_addr1", mem_address, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      drive(1'b0, 64'h0, 1'b0);
      chk("wrap_addr2", mem_address, 64'h0);
      chk("wrap_head", instr_pc, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      drive(1'b1, 64'h40, 1'b1);
      chk("redir_pop_valid", {63'h0, instr_valid}, 64'h1);
      tick();
      drive(1'b0, 64'h0, 1'b0);
      chk("redir_pop_dropped", {63'h0, instr_valid}, 64'h0);
      chk("redir_pop_addr", mem_address, 64'h40);
      tick();

      // asynchronous reset in the middle of a cycle with a half-full FIFO
      drive(1'b0, 64'h0, 1'b0);
      tick();
      drive(1'b0, 64'h0, 1'b0);
      chk("mid_before_valid", {63'h0, instr_valid}, 64'h1);
      #1 reset = 1'b1;
      #1;
      chk_zero_outputs("midrst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 64'h0, 1'b1);
      chk("midrst_c0_en", {63'h0, mem_enable}, 64'h0);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("midrst_c1_en", {63'h0, mem_enable}, 64'h1);
      chk("midrst_c1_valid", {63'h0, instr_valid}, 64'h0);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("midrst_c2_pc", instr_pc, 64'h0);
      chk("midrst_c2_valid", {63'h0, instr_valid}, 64'h1);
      tick();

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic        rv;
         logic [63:0] rpc;
         int          sel;
         rv  = ($urandom_range(0, 9) == 0);
         sel = $urandom_range(0, 7);
         if (sel == 0)      rpc = {$urandom, $urandom};
         else if (sel == 1) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
         else               rpc = {32'h0, $urandom} & ~64'h3;
         drive(rv, rpc, 1'($urandom_range(0, 1)));
         check_model();
         tick();
      end

      // misaligned redirect
      do_reset();
      drive(1'b0, 64'h0, 1'b1);
      tick();
      drive(1'b1, 64'h6, 1'b1);
      tick();
`ifdef FETCH_ALIGN_CHECK_EN
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'h100, 1'b1);
         chk($sformatf("mis%0d_fault", i), {63'h0, fault}, 64'h1);
         chk($sformatf("mis%0d_en", i), {63'h0, mem_enable}, 64'h0);
         chk($sformatf("mis%0d_valid", i), {63'h0, instr_valid}, 64'h0);
         tick();
      end
`else
      drive(1'b0, 64'h0, 1'b1);
      chk("mis_addr", mem_address, 64'h4);
      chk("mis_en", {63'h0, mem_enable}, 64'h1);
      chk("mis_fault", {63'h0, fault}, 64'h0);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("mis_head", instr_pc, 64'h4);
      chk("mis_fault2", {63'h0, fault}, 64'h0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
